sha256_result_check: RTL and testbench

//  Tail of the unrolled SHA-256 mining pipeline. Consumes the 256-bit {a..h} state leaving the round-64 stage.

---
 rtl/sha256_pkg.sv | 37 +++
 rtl/sha256_hit_fifo.sv | 76 +++++++
 rtl/sha256_result_check.sv | 112 +++++++++++
 tb/tb_sha256_result_check.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// ---------------------------------------------------------------------------
// sha256_pkg : shared SHA-256 widths, initial hash and word/zero-count helpers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sha256_pkg;
  localparam int SHA_WORD_W  = 32;
  localparam int SHA_STATE_W = 256;
  localparam int SHA_WORDS   = SHA_STATE_W / SHA_WORD_W;

  localparam logic [SHA_STATE_W-1:0] H0 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [SHA_WORD_W-1:0] bswap32(input logic [SHA_WORD_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Count of leading zero bits; an all-zero vector yields 256.
  function automatic logic [8:0] lzc256(input logic [SHA_STATE_W-1:0] v);
    logic [8:0] n;
    logic       found;
    n     = 9'd256;
    found = 1'b0;
    for (int i = SHA_STATE_W - 1; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 9'(SHA_STATE_W - 1 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction
endpackage

`default_nettype wire

// File: rtl/sha256_hit_fifo.sv
// ---------------------------------------------------------------------------
// sha256_hit_fifo : synchronous first-word-fall-through FIFO with level output
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sha256_hit_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 288
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic                     rvalid,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q,  level_d;
  logic             do_push;
  logic             do_pop;

  assign rvalid = (level_q != '0);
  assign full   = (level_q == (AW+1)'(DEPTH));
  assign rdata  = mem_q[rd_ptr_q];
  assign level  = level_q;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_pop  = pop && rvalid;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      level_d = level_q + (AW+1)'(1);
    end else if (do_pop && !do_push) begin
      level_d = level_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end
endmodule

`default_nettype wire

// File: rtl/sha256_result_check.sv
// ---------------------------------------------------------------------------
// sha256_result_check : feed-forward add, difficulty test and hit buffering
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sha256_result_check
  import sha256_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int NONCE_W    = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [NONCE_W-1:0]            in_nonce,
  input  logic [SHA_STATE_W-1:0]        in_state,
  input  logic [SHA_STATE_W-1:0]        h_init,
  input  logic [8:0]                    target_zeros,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NONCE_W-1:0]            out_nonce,
  output logic [SHA_STATE_W-1:0]        out_hash,
  output logic [31:0]                   hit_count,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  logic                   s1_valid_q,  s1_valid_d;
  logic [NONCE_W-1:0]     s1_nonce_q,  s1_nonce_d;
  logic [SHA_STATE_W-1:0] s1_digest_q, s1_digest_d;
  logic                   s2_hit_q,    s2_hit_d;
  logic [NONCE_W-1:0]     s2_nonce_q,  s2_nonce_d;
  logic [SHA_STATE_W-1:0] s2_digest_q, s2_digest_d;
  logic [31:0]            hit_count_q, hit_count_d;
  logic                   overflow_q,  overflow_d;

  logic [SHA_STATE_W-1:0] chk;
  logic [8:0]             lzc;
  logic                   fifo_full;
  logic                   pop;
  logic [NONCE_W+SHA_STATE_W-1:0] head;

  // Byte-reverse each word and reverse word order so D7 lands in the MSBs.
  always_comb begin
    chk = '0;
    for (int k = 0; k < SHA_WORDS; k++) begin
      chk[SHA_STATE_W-1-SHA_WORD_W*k -: SHA_WORD_W] = bswap32(s1_digest_q[SHA_WORD_W*k +: SHA_WORD_W]);
    end
  end

  assign lzc = lzc256(chk);
  assign pop = out_valid && out_ready;

  always_comb begin
    s1_valid_d  = in_valid;
    s1_nonce_d  = in_nonce;
    s1_digest_d = '0;
    for (int i = 0; i < SHA_WORDS; i++) begin
      s1_digest_d[SHA_WORD_W*i +: SHA_WORD_W] =
        h_init[SHA_WORD_W*i +: SHA_WORD_W] + in_state[SHA_WORD_W*i +: SHA_WORD_W];
    end
    s2_hit_d    = s1_valid_q && (lzc >= target_zeros);
    s2_nonce_d  = s1_nonce_q;
    s2_digest_d = s1_digest_q;
    hit_count_d = hit_count_q + (s2_hit_q ? 32'd1 : 32'd0);
    overflow_d  = overflow_q || (s2_hit_q && fifo_full && !pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_nonce_q  <= '0;
      s1_digest_q <= '0;
      s2_hit_q    <= 1'b0;
      s2_nonce_q  <= '0;
      s2_digest_q <= '0;
      hit_count_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_nonce_q  <= s1_nonce_d;
      s1_digest_q <= s1_digest_d;
      s2_hit_q    <= s2_hit_d;
      s2_nonce_q  <= s2_nonce_d;
      s2_digest_q <= s2_digest_d;
      hit_count_q <= hit_count_d;
      overflow_q  <= overflow_d;
    end
  end

  sha256_hit_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (NONCE_W + SHA_STATE_W)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (s2_hit_q),
    .wdata  ({s2_nonce_q, s2_digest_q}),
    .pop    (pop),
    .rvalid (out_valid),
    .rdata  (head),
    .full   (fifo_full),
    .level  (fifo_level)
  );

  assign out_nonce = head[NONCE_W+SHA_STATE_W-1 -: NONCE_W];
  assign out_hash  = head[SHA_STATE_W-1:0];
  assign hit_count = hit_count_q;
  assign overflow  = overflow_q;
endmodule

`default_nettype wire

// File: tb/tb_sha256_result_check.sv
// ---------------------------------------------------------------------------
// tb_sha256_result_check : directed self-checking bench for sha256_result_check
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sha256_result_check;
  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [31:0]  in_nonce;
  logic [255:0] in_state;
  logic [255:0] h_init;
  logic [8:0]   target_zeros;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_nonce;
  logic [255:0] out_hash;
  logic [31:0]  hit_count;
  logic         overflow;
  logic [2:0]   fifo_level;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sha256_result_check #(
    .FIFO_DEPTH (4),
    .NONCE_W    (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_nonce     (in_nonce),
    .in_state     (in_state),
    .h_init       (h_init),
    .target_zeros (target_zeros),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_nonce    (out_nonce),
    .out_hash     (out_hash),
    .hit_count    (hit_count),
    .overflow     (overflow),
    .fifo_level   (fifo_level)
  );

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] nonce, input logic [255:0] state);
    in_valid = 1'b1;
    in_nonce = nonce;
    in_state = state;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    in_valid     = 1'b1;
    in_nonce     = 32'hdeadbeef;
    in_state     = '0;
    h_init       = '0;
    target_zeros = 9'd0;
    out_ready    = 1'b0;

    // Reset held with live hit-worthy input: nothing may leak afterwards.
    tick(); tick(); tick();
    check_eq("rst_valid", 256'(out_valid), 256'd0);
    check_eq("rst_hits", 256'(hit_count), 256'd0);
    check_eq("rst_level", 256'(fifo_level), 256'd0);
    check_eq("rst_hash", out_hash, 256'd0);
    reset    = 1'b0;
    in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    check_eq("post_rst_valid", 256'(out_valid), 256'd0);
    check_eq("post_rst_hits", 256'(hit_count), 256'd0);

    // All-zero digest against the maximum target, with latency checks.
    target_zeros = 9'd256;
    send(32'h12345678, '0);
    check_eq("lat_n1", 256'(out_valid), 256'd0);
    tick();
    check_eq("lat_n2", 256'(out_valid), 256'd0);
    tick();
    check_eq("lat_n3", 256'(out_valid), 256'd1);
    check_eq("zero_hash", out_hash, 256'd0);
    check_eq("zero_nonce", 256'(out_nonce), 256'h12345678);
    check_eq("zero_hits", 256'(hit_count), 256'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("zero_pop_level", 256'(fifo_level), 256'd0);

    // Feed-forward carry wraps inside the word.
    target_zeros = 9'd0;
    h_init = {32'hffffffff, 224'd0};
    send(32'h00000003, {32'h00000002, 224'd0});
    tick(); tick();
    check_eq("wrap_hash", out_hash, {32'h00000001, 224'd0});
    check_eq("wrap_hits", 256'(hit_count), 256'd2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Exactly 32 leading zeros after the byte swap hits; 31 misses.
    h_init = '0;
    target_zeros = 9'd32;
    send(32'h00000004, {192'd0, 32'h00000080, 32'h00000000});
    tick(); tick();
    check_eq("lzc32_valid", 256'(out_valid), 256'd1);
    check_eq("lzc32_hash", out_hash, {192'd0, 32'h00000080, 32'h00000000});
    check_eq("lzc32_hits", 256'(hit_count), 256'd3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    send(32'h00000005, {224'd0, 32'h01000000});
    tick(); tick();
    check_eq("lzc31_valid", 256'(out_valid), 256'd0);
    check_eq("lzc31_hits", 256'(hit_count), 256'd3);

    // Targets beyond 256 can never be met.
    target_zeros = 9'd257;
    send(32'h00000006, '0);
    tick(); tick();
    check_eq("tgt257_hits", 256'(hit_count), 256'd3);

    // Five back-to-back hits into a 4-deep FIFO with no reader.
    do_reset();
    target_zeros = 9'd0;
    for (int k = 1; k <= 5; k++) begin
      in_valid = 1'b1;
      in_nonce = 32'(k);
      in_state = {32'(k), 224'd0};
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    check_eq("ovf_level", 256'(fifo_level), 256'd4);
    check_eq("ovf_flag", 256'(overflow), 256'd1);
    check_eq("ovf_hits", 256'(hit_count), 256'd5);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check_eq("drain_valid", 256'(out_valid), 256'd1);
      check_eq("drain_nonce", 256'(out_nonce), 256'(k));
      check_eq("drain_hash", out_hash, {32'(k), 224'd0});
      tick();
    end
    out_ready = 1'b0;
    check_eq("drain_empty", 256'(out_valid), 256'd0);

    // Simultaneous pop and push on a full FIFO.
    do_reset();
    for (int k = 11; k <= 14; k++) begin
      in_valid = 1'b1;
      in_nonce = 32'(k);
      in_state = '0;
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    check_eq("full_level", 256'(fifo_level), 256'd4);
    send(32'd15, '0);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("pp_level", 256'(fifo_level), 256'd4);
    check_eq("pp_overflow", 256'(overflow), 256'd0);
    check_eq("pp_hits", 256'(hit_count), 256'd5);
    check_eq("pp_head", 256'(out_nonce), 256'd12);
    tick();
    do_reset();
    check_eq("final_level", 256'(fifo_level), 256'd0);
    check_eq("final_valid", 256'(out_valid), 256'd0);
    check_eq("final_hits", 256'(hit_count), 256'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

`default_nettype wire
